// File: rtl/rr_arb_stage_pkg.sv
// Shared arbitration helpers: round-robin pick and one-hot encoder, sized for up to
// ARB_MAX_N requesters so other arbiters can reuse them.
package rr_arb_stage_pkg;

  localparam int unsigned ARB_MAX_N = 16;
  localparam int unsigned ARB_IDX_W = 4;

  typedef logic [ARB_MAX_N-1:0] arb_vec_t;
  typedef logic [ARB_IDX_W-1:0] arb_idx_t;
  typedef logic [ARB_IDX_W:0]   arb_sum_t;

  function automatic arb_idx_t onehot_to_idx(input arb_vec_t oh);
    arb_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | arb_idx_t'(i);
    end
    return idx;
  endfunction

  // Scan n requesters starting at ptr, wrapping modulo n; first set bit wins.
  function automatic arb_vec_t rr_pick(input arb_vec_t req, input arb_idx_t ptr,
                                       input int unsigned n);
    arb_vec_t gnt;
    arb_sum_t idx;
    logic     found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      idx = {1'b0, arb_idx_t'(i)} + {1'b0, ptr};
      if (idx >= arb_sum_t'(n)) idx = idx - arb_sum_t'(n);
      if ((i < n) && !found && req[idx[ARB_IDX_W-1:0]]) begin
        gnt[idx[ARB_IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arb_stage_if.sv
// Request/response bundle of the round-robin arbitration stage.
interface rr_arb_stage_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_grant;
  logic [IW-1:0]  out_src;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_grant, out_src
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_grant, out_src
  );
endinterface

// File: rtl/rr_arb_stage_premux.sv
// One-hot mux with a pre-decoded select; an all-zero select yields zero.
module rr_arb_stage_premux #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] in,
  output logic [W-1:0]   out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < N; i++) begin
      out = out | (in[i*W +: W] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/rr_arb_stage.sv
// Registered round-robin arbitration stage feeding a single valid/ready output register.
// Define ARB_LOCK_EN to hold the grant on one requester until its req_last beat.
module rr_arb_stage
  import rr_arb_stage_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input logic           clk,
  input logic           rst_n,
  rr_arb_stage_if.slave bus
);

  logic          load;
  logic          accept;
  logic [N-1:0]  gnt;
  logic [W-1:0]  mux_data;
  arb_vec_t      pick;
  arb_idx_t      win_full;
  logic [IW-1:0] winner;
  logic [IW-1:0] ptr_inc;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          unused_pick;
  logic          unused_win;

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [N-1:0]  out_grant_q;
  logic [IW-1:0] out_src_q;

  assign load   = ~out_valid_q | bus.out_ready;
  assign accept = load & (|gnt);

  always_comb pick = rr_pick(ARB_MAX_N'(bus.req_valid), ARB_IDX_W'(ptr_q), N);
  assign unused_pick = ^pick;

  always_comb win_full = onehot_to_idx(ARB_MAX_N'(gnt));
  assign winner     = win_full[IW-1:0];
  assign unused_win = ^win_full;

  assign ptr_inc = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;

`ifdef ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic          acc_last;

  // A locked packet owns the grant even while its requester idles.
  always_comb begin
    gnt = pick[N-1:0];
    if (lock_q) gnt = (N'(1) << lock_id_q) & bus.req_valid;
  end

  assign acc_last = |(gnt & bus.req_last);

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    if (accept) begin
      if (acc_last) begin
        lock_d = 1'b0;
        ptr_d  = ptr_inc;
      end else if (!lock_q) begin
        lock_d    = 1'b1;
        lock_id_d = winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  logic unused_last;

  assign gnt         = pick[N-1:0];
  assign unused_last = ^bus.req_last;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ptr_inc;
  end
`endif

  rr_arb_stage_premux #(
    .W(W),
    .N(N)
  ) u_premux (
    .sel(gnt),
    .in (bus.req_data),
    .out(mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // An empty grant clears the output, so grant/src read zero whenever valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
      out_src_q   <= '0;
    end else if (load) begin
      out_valid_q <= |gnt;
      out_data_q  <= mux_data;
      out_grant_q <= gnt;
      out_src_q   <= winner;
    end
  end

  assign bus.req_ready = gnt & {N{load}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_grant = out_grant_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb_stage.sv
// Directed and randomized bench for rr_arb_stage against a scan-order reference model.
module tb_rr_arb_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arb_stage_if #(.W(W), .N(N), .IW(IW)) bus ();

  rr_arb_stage #(.W(W), .N(N), .IW(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  int            m_ptr;
  bit            m_lock;
  int            m_lock_id;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic [N-1:0]  m_grant;
  logic [IW-1:0] m_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_lock    = 1'b0;
    m_lock_id = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_grant   = '0;
    m_src     = '0;
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    bit           found;
    int           idx;
    g     = '0;
    found = 1'b0;
    if (m_lock) begin
      if (bus.req_valid[m_lock_id]) g[m_lock_id] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && bus.req_valid[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = $urandom;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    logic [N-1:0] g;
    logic         ld;
    int           w;
    logic [W-1:0] d;
    #1;
    g  = model_gnt();
    ld = !m_valid || bus.out_ready;
    chk("req_ready", {60'd0, bus.req_ready}, {60'd0, (ld ? g : 4'b0000)});
    w = 0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        w = i;
        d = bus.req_data[i*W +: W];
      end
    end
    @(posedge clk);
    if (ld) begin
      m_valid = |g;
      m_data  = d;
      m_grant = g;
      m_src   = IW'(w);
      if (|g) begin
`ifdef ARB_LOCK_EN
        if (bus.req_last[w]) begin
          m_lock = 1'b0;
          m_ptr  = (w + 1) % N;
        end else if (!m_lock) begin
          m_lock    = 1'b1;
          m_lock_id = w;
        end
`else
        m_ptr = (w + 1) % N;
`endif
      end
    end
    #1;
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
    chk("out_data",  {32'd0, bus.out_data},  {32'd0, m_data});
    chk("out_grant", {60'd0, bus.out_grant}, {60'd0, m_grant});
    chk("out_src",   {62'd0, bus.out_src},   {62'd0, m_src});
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '1;
    bus.out_ready = 1'b1;
    model_reset();

    #10;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data",  {32'd0, bus.out_data},  64'd0);
    chk("rst_grant", {60'd0, bus.out_grant}, 64'd0);
    chk("rst_src",   {62'd0, bus.out_src},   64'd0);
    chk("rst_ready", {60'd0, bus.req_ready}, 64'd1);
    bus.req_valid = '0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All requesters valid: strict rotation starting at 0.
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      step();
      chk("rr_seq", {62'd0, bus.out_src}, 64'(k % 4));
    end

    // Move ptr to 2, then requester 0 wins the wrap, then 1 ahead of 0.
    bus.req_valid = 4'b0010;
    rand_data();
    step();
    bus.req_valid = 4'b0011;
    rand_data();
    step();
    chk("wrap_win0", {62'd0, bus.out_src}, 64'd0);
    rand_data();
    step();
    chk("next_win1", {62'd0, bus.out_src}, 64'd1);

    // Full stall for three cycles, then release with back-to-back capture.
    bus.req_valid = 4'b1111;
    rand_data();
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      step();
      chk("stall_src", {62'd0, bus.out_src}, 64'd2);
    end
    bus.out_ready = 1'b1;
    rand_data();
    step();
    chk("release_src", {62'd0, bus.out_src}, 64'd3);

    // Idle cycles must leave ptr untouched.
    bus.req_valid = 4'b0000;
    step();
    bus.req_valid = 4'b1111;
    rand_data();
    step();
    chk("idle_win0", {62'd0, bus.out_src}, 64'd0);
    bus.req_valid = 4'b0000;
    step();
    chk("idle_grant", {60'd0, bus.out_grant}, 64'd0);
    bus.req_valid = 4'b1111;
    rand_data();
    step();
    chk("idle_win1", {62'd0, bus.out_src}, 64'd1);

    // Asynchronous reset between edges.
    rand_data();
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_grant", {60'd0, bus.out_grant}, 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    rand_data();
    step();
    chk("arst_first", {62'd0, bus.out_src}, 64'd0);

`ifdef ARB_LOCK_EN
    // ptr is 1: requester 1 locks for a 3-beat packet, with a gap mid-packet.
    bus.req_valid = 4'b0011;
    bus.req_last  = 4'b1101;
    rand_data();
    step();
    chk("lock_b0", {62'd0, bus.out_src}, 64'd1);
    rand_data();
    step();
    chk("lock_b1", {62'd0, bus.out_src}, 64'd1);
    bus.req_valid = 4'b0001;
    rand_data();
    step();
    chk("lock_gap", {63'd0, bus.out_valid}, 64'd0);
    bus.req_valid = 4'b0011;
    bus.req_last  = 4'b1111;
    rand_data();
    step();
    chk("lock_b2", {62'd0, bus.out_src}, 64'd1);
    rand_data();
    step();
    chk("lock_after", {62'd0, bus.out_src}, 64'd0);
`endif

    // Randomized traffic, backpressure and last flags.
    for (int k = 0; k < 400; k++) begin
      bus.req_valid = N'($urandom);
      bus.req_last  = N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arb_stage.md
Name: rr_arb_stage

Overview:
- Registered round-robin arbitration stage with N requesters.
- Computes a one-hot grant each cycle and uses it as the pre-decoded select of a one-hot mux to pick one requester's payload.
- Captures the winning payload into a single output register with valid/ready handshake.
- Sits directly upstream of any consumer that takes one-hot selects: shared result buses, writeback ports, memory request queues.

Parameters:
- W, 32, payload width per requester in bits.
- N, 4, number of requesters (2..16).
- IW, $clog2(N), width of the encoded source index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester valid.
- req_data  in  N*W  packed payloads; requester i occupies bits [i*W +: W].
- req_last  in  N  per-requester last-beat flag; used only with ARB_LOCK_EN.
- req_ready  out  N  one-hot accept; a beat transfers when req_valid[i] & req_ready[i].
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  W  registered payload.
- out_grant  out  N  registered one-hot source of out_data; all zero when out_valid=0.
- out_src  out  IW  encoded index matching out_grant; 0 when out_valid=0.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_grant=0, out_src=0, priority pointer ptr=0, lock state cleared. req_ready is combinational and reads 0 while the output is full and stalled.
- Load enable: load = ~out_valid | out_ready.
- Combinational grant gnt: one-hot, or zero if no req_valid.
  - Scan starts at index ptr and wraps modulo N; the first set req_valid bit wins.
  - Scan order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- req_ready = gnt & {N{load}}. Only one requester is ever ready, and only when it is valid.
- Payload path: one-hot mux on gnt selects the payload. With gnt=0 the mux yields 0.
- On the clock edge when load=1:
  - out_valid <= |gnt; out_data <= mux result; out_grant <= gnt; out_src <= encode(gnt).
  - If |gnt: ptr <= (winner+1) mod N. If no requester is valid, ptr is unchanged.
- When load=0: all output registers and ptr hold. out_data, out_grant and out_src are stable while out_valid & ~out_ready.
- Latency: one cycle from accepted request to out_valid. Full throughput, one beat per cycle, while out_ready=1.
- Simultaneous out_ready and a new grant: the old beat leaves and the new beat is captured in the same edge; there is no bubble.
- Fairness: any continuously valid requester is granted within N winning beats.
- Pointer wrap: a winner at N-1 sets ptr to 0.
- A requester dropping req_valid without being granted is legal. Its data is ignored.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - A beat accepted from requester i with req_last[i]=0 sets lock=1 and records lock_id=i.
  - While lock=1, gnt is forced to one-hot(lock_id) & req_valid. Other requesters are not granted even if lock_id is idle.
  - lock clears on acceptance of a beat from lock_id with req_last=1. ptr advances only on that final beat.
  - Reset clears the lock at any point, including mid-packet.
- When undefined: req_last is ignored and each beat arbitrates independently.

Decomposition:
- Shared package:
  - Constant ARB_MAX_N=16.
  - Function onehot_to_idx (one-hot to index encoder).
  - Function rr_pick (rotate, priority-find, unrotate), reusable by other arbiters.
- Sub-module: premux (W, N), instantiated for the payload path with sel=gnt and in=req_data.
- The grant logic stays in this module.

Test Plan:
- Reset, then N=4, all four req_valid=1 held, out_ready=1 → out_src sequence 0,1,2,3,0 on consecutive cycles; out_data matches each requester's payload.
- ptr=2, req_valid=4'b0011 → requester 0 granted; next cycle ptr=1, so requester 1 is granted before 0.
- Full stall: out_valid=1, out_ready=0 for 3 cycles with req_valid=4'b1111 → req_ready=0, out_data/out_grant/ptr unchanged; on release, transfer and new capture occur in the same edge.
- No requests: req_valid=0, out_ready=1 → out_valid falls to 0, out_grant=0, ptr unchanged.
- Async reset asserted mid-stream (rst_n low between clock edges) → out_valid=0 and out_grant=0 immediately; after release, first grant goes to requester 0.
- ARB_LOCK_EN: requester 1 sends 3 beats with req_last=0,0,1 while requester 0 is always valid → out_src=1,1,1, then 0; a gap in requester 1 valid mid-packet grants no one.
